sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_PRIO, default 0, arbitration mode: 0 = round-robin on conflict, 1 = fixed data-side priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  fetch requester requests a read.
REQ-005 inst_addr  input  32  fetch read address.
REQ-006 inst_addr_ok  output  1  fetch request granted this cycle.
REQ-007 inst_data_ok  output  1  fetch response valid this cycle.
REQ-008 inst_rdata  output  32  fetch read data.
REQ-009 data_req  input  1  load/store requester requests an access.
REQ-010 data_wr  input  1  1 = write, 0 = read.
REQ-011 data_wstrb  input  4  byte enables for writes.
REQ-012 data_addr  input  32  access address.
REQ-013 data_wdata  input  32  write data.
REQ-014 data_addr_ok  output  1  data request granted this cycle.
REQ-015 data_data_ok  output  1  data response valid this cycle; acknowledges writes too.
REQ-016 data_rdata  output  32  load data.
REQ-017 sram_en  output  1  shared SRAM port access strobe.
REQ-018 sram_we  output  4  shared SRAM byte write enables.
REQ-019 sram_addr  output  32  shared SRAM address.
REQ-020 sram_wdata  output  32  shared SRAM write data.
REQ-021 sram_rdata  input  32  SRAM read data, valid exactly one cycle after a read strobe.
REQ-022 conflict_cnt  output  16  count of cycles in which both requesters asserted req.

Function
REQ-023 The block SHALL be a three-state FSM: IDLE (no response pending), RESP_I (fetch response due), RESP_D (data response due).
REQ-024 Grants SHALL be combinational from req and may be issued in any state, giving one grant per cycle at most.
REQ-025 Only inst_req asserted -> fetch granted; only data_req asserted -> data granted.
REQ-026 When both are asserted and DATA_PRIO=1, data SHALL be granted.
REQ-027 When both are asserted and DATA_PRIO=0, the side not granted most recently SHALL be granted; last_grant register updates on every grant.
REQ-028 On a grant, the granted addr_ok SHALL be 1, sram_en=1, sram_addr=granted address; sram_we=data_wstrb for a data write, else 4'b0; sram_wdata=data_wdata for a data write, else 0.
REQ-029 With no grant, sram_en, sram_we, sram_addr and sram_wdata SHALL all be 0.
REQ-030 Next state SHALL be RESP_I after a fetch grant, RESP_D after a data grant, and IDLE otherwise.
REQ-031 In RESP_I, inst_data_ok=1 and inst_rdata=sram_rdata; otherwise inst_data_ok=0 and inst_rdata=0.
REQ-032 In RESP_D, data_data_ok=1; data_rdata=sram_rdata for a read and 0 for a write, using a registered resp_is_write flag.
REQ-033 Response latency SHALL be exactly one cycle after addr_ok; back-to-back grants SHALL yield back-to-back data_ok pulses.
REQ-034 A requester SHALL hold req and its payload until addr_ok; the block SHALL sample the payload only in the grant cycle.
REQ-035 conflict_cnt SHALL increment when inst_req and data_req are both 1, saturating at 16'hFFFF.

Reset
REQ-036 While reset is high: state=IDLE; last_grant=fetch, so data wins the first round-robin conflict; resp_is_write=0; conflict_cnt=0; all addr_ok, data_ok, rdata and sram_* outputs=0.
REQ-037 Reset asserted in the cycle after a grant SHALL drop that response; data_ok SHALL stay 0 in that cycle and the next.

Verification
REQ-038 Fetch only: inst_req=1, inst_addr=0x1C000000 -> same cycle inst_addr_ok=1, sram_en=1, sram_we=0; next cycle inst_data_ok=1, inst_rdata=sram_rdata.
REQ-039 Store: data_req=1, data_wr=1, data_wstrb=4'b0011, data_addr=0x100, data_wdata=0xDEADBEEF -> sram_we=0011, sram_wdata=0xDEADBEEF; next cycle data_data_ok=1, data_rdata=0.
REQ-040 DATA_PRIO=0, both reqs held 4 cycles from reset -> grants in order D, I, D, I; data_ok pulses in order D, I, D, I; conflict_cnt=4.
REQ-041 DATA_PRIO=1, both reqs held 3 cycles -> data granted 3 times; inst_addr_ok stays 0.
REQ-042 Grant fetch, then reset high the next cycle -> inst_data_ok=0; after reset, state=IDLE and conflict_cnt=0.
REQ-043 Force conflict_cnt to 0xFFFE, then hold 3 conflict cycles -> conflict_cnt=0xFFFF with no wrap.

Source files
------------

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Bundle of the fetch port, load/store port and shared SRAM
//                port seen by the SRAM arbiter.
//                  fetch  : inst_req/inst_addr in; inst_addr_ok,
//                           inst_data_ok, inst_rdata out
//                  data   : data_req/wr/wstrb/addr/wdata in; data_addr_ok,
//                           data_data_ok, data_rdata out
//                  sram   : sram_en/we/addr/wdata out; sram_rdata in
//                  status : conflict_cnt out
//                The slave modport is the arbiter's view.
//                The master modport is the view of the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [15:0] conflict_cnt;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata,
    output conflict_cnt
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata,
    input  conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Shares one single-cycle SRAM port between a fetch requester
//                and a load/store requester. Grants are combinational, and
//                each granted access returns its response exactly one cycle
//                later.
//                  clk   : single clock, rising edge
//                  reset : synchronous, active-high
//                  bus   : sram_arbiter_if.slave (all request, response,
//                          SRAM and status signals)
//                  DATA_PRIO : 0 = round-robin on conflict,
//                              1 = data side always wins a conflict
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int DATA_PRIO = 0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  sram_arbiter_if.slave   bus
);

  localparam bit         c_DATA_PRIO = (DATA_PRIO != 0);
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESP_I = 2'd1,
    S_RESP_D = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_data;      // 1 = most recent grant went to the data side
  logic        r_resp_is_write;
  logic [15:0] r_conflict_cnt;

  logic w_conflict;
  logic w_grant_i;
  logic w_grant_d;
  logic w_wr;

  // Under a conflict, data wins if it is fixed-priority or if fetch was
  // served last. Reset suppresses all grants so nothing leaks onto the SRAM.
  always_comb begin
    w_conflict = bus.inst_req && bus.data_req;
    w_grant_d  = !reset && bus.data_req &&
                 (!bus.inst_req || c_DATA_PRIO || !r_last_data);
    w_grant_i  = !reset && bus.inst_req && !w_grant_d;
    w_wr       = w_grant_d && bus.data_wr;
  end

  // Grant-cycle SRAM drive; all fields are zero when idle.
  always_comb begin
    bus.inst_addr_ok = w_grant_i;
    bus.data_addr_ok = w_grant_d;
    bus.sram_en      = w_grant_i || w_grant_d;
    bus.sram_we      = w_wr ? bus.data_wstrb : 4'b0000;
    bus.sram_wdata   = w_wr ? bus.data_wdata : 32'h0;
    if (w_grant_d) begin
      bus.sram_addr = bus.data_addr;
    end else if (w_grant_i) begin
      bus.sram_addr = bus.inst_addr;
    end else begin
      bus.sram_addr = 32'h0;
    end
  end

  // Responses come from the registered state. Gating with reset drops a
  // response whose grant happened just before reset was raised.
  always_comb begin
    bus.inst_data_ok = !reset && (r_state == S_RESP_I);
    bus.inst_rdata   = bus.inst_data_ok ? bus.sram_rdata : 32'h0;
    bus.data_data_ok = !reset && (r_state == S_RESP_D);
    bus.data_rdata   = (bus.data_data_ok && !r_resp_is_write) ? bus.sram_rdata : 32'h0;
    bus.conflict_cnt = r_conflict_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_last_data     <= 1'b0;
      r_resp_is_write <= 1'b0;
      r_conflict_cnt  <= 16'h0;
    end else begin
      if (w_grant_d) begin
        r_state         <= S_RESP_D;
        r_last_data     <= 1'b1;
        r_resp_is_write <= bus.data_wr;
      end else if (w_grant_i) begin
        r_state     <= S_RESP_I;
        r_last_data <= 1'b0;
      end else begin
        r_state <= S_IDLE;
      end

      if (w_conflict && (r_conflict_cnt != c_CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter. dut0 runs in
//                round-robin mode and dut1 runs in fixed data-priority mode.
//                Both share the clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sram_arbiter_if if0 ();
  sram_arbiter_if if1 ();

  sram_arbiter #(.DATA_PRIO(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  sram_arbiter #(.DATA_PRIO(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.inst_req = 0; if0.inst_addr = 0; if0.data_req = 0; if0.data_wr = 0;
    if0.data_wstrb = 0; if0.data_addr = 0; if0.data_wdata = 0; if0.sram_rdata = 0;
    if1.inst_req = 0; if1.inst_addr = 0; if1.data_req = 0; if1.data_wr = 0;
    if1.data_wstrb = 0; if1.data_addr = 0; if1.data_wdata = 0; if1.sram_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    if0.inst_req = 1; if0.data_req = 1; if0.inst_addr = 32'h40; if0.data_addr = 32'h80;
    step(); step();
    #1;
    vectors++;
    if ({if0.inst_addr_ok, if0.data_addr_ok, if0.sram_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_grants: got %b required 000", {if0.inst_addr_ok, if0.data_addr_ok, if0.sram_en});
    end
    vectors++;
    if ({if0.sram_we, if0.sram_addr, if0.sram_wdata} !== 68'h0) begin
      miscompares++;
      $display("FAIL reset_sram: got we=%b addr=%h wdata=%h required 0", if0.sram_we, if0.sram_addr, if0.sram_wdata);
    end
    vectors++;
    if (if0.conflict_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %h required 0000", if0.conflict_cnt);
    end
    idle_inputs();
    reset = 0;
    step();
  endtask

  task automatic test_fetch();
    if0.inst_req = 1; if0.inst_addr = 32'h1C00_0000;
    #1;
    vectors++;
    if ({if0.inst_addr_ok, if0.data_addr_ok, if0.sram_en, if0.sram_we} !== 7'b1010000) begin
      miscompares++;
      $display("FAIL fetch_grant: got ok_i=%b ok_d=%b en=%b we=%b required 1 0 1 0000",
               if0.inst_addr_ok, if0.data_addr_ok, if0.sram_en, if0.sram_we);
    end
    vectors++;
    if (if0.sram_addr !== 32'h1C00_0000 || if0.sram_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_addr: got addr=%h wdata=%h required 1c000000 0", if0.sram_addr, if0.sram_wdata);
    end
    step();
    if0.inst_req = 0; if0.sram_rdata = 32'h1234_5678;
    #1;
    vectors++;
    if (if0.inst_data_ok !== 1'b1 || if0.inst_rdata !== 32'h1234_5678 || if0.data_data_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_resp: got ok=%b rdata=%h dok=%b required 1 12345678 0",
               if0.inst_data_ok, if0.inst_rdata, if0.data_data_ok);
    end
    vectors++;
    if (if0.sram_en !== 1'b0 || if0.sram_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_idle_sram: got en=%b addr=%h required 0 0", if0.sram_en, if0.sram_addr);
    end
    step();
    vectors++;
    if (if0.inst_data_ok !== 1'b0 || if0.inst_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_single_pulse: got ok=%b rdata=%h required 0 0", if0.inst_data_ok, if0.inst_rdata);
    end
    if0.sram_rdata = 0;
  endtask

  task automatic test_store();
    if0.data_req = 1; if0.data_wr = 1; if0.data_wstrb = 4'b0011;
    if0.data_addr = 32'h100; if0.data_wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (if0.data_addr_ok !== 1'b1 || if0.sram_en !== 1'b1 || if0.sram_we !== 4'b0011 ||
        if0.sram_wdata !== 32'hDEAD_BEEF || if0.sram_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL store_grant: got ok=%b en=%b we=%b wdata=%h addr=%h required 1 1 0011 deadbeef 100",
               if0.data_addr_ok, if0.sram_en, if0.sram_we, if0.sram_wdata, if0.sram_addr);
    end
    step();
    idle_inputs();
    if0.sram_rdata = 32'hCAFE_F00D;
    #1;
    vectors++;
    if (if0.data_data_ok !== 1'b1 || if0.data_rdata !== 32'h0 || if0.inst_data_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL store_resp: got ok=%b rdata=%h iok=%b required 1 0 0",
               if0.data_data_ok, if0.data_rdata, if0.inst_data_ok);
    end
    step();
  endtask

  task automatic test_load();
    if0.data_req = 1; if0.data_wr = 0; if0.data_wstrb = 4'b1111;
    if0.data_addr = 32'h200; if0.data_wdata = 32'h5555_AAAA;
    #1;
    vectors++;
    if (if0.data_addr_ok !== 1'b1 || if0.sram_we !== 4'b0000 || if0.sram_wdata !== 32'h0 ||
        if0.sram_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL load_grant: got ok=%b we=%b wdata=%h addr=%h required 1 0000 0 200",
               if0.data_addr_ok, if0.sram_we, if0.sram_wdata, if0.sram_addr);
    end
    step();
    idle_inputs();
    if0.sram_rdata = 32'h0BAD_F00D;
    #1;
    vectors++;
    if (if0.data_data_ok !== 1'b1 || if0.data_rdata !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL load_resp: got ok=%b rdata=%h required 1 0badf00d", if0.data_data_ok, if0.data_rdata);
    end
    step();
    if0.sram_rdata = 0;
  endtask

  // Round-robin from reset: expected grant order D, I, D, I.
  task automatic test_round_robin();
    logic [3:0] exp_d;
    exp_d = 4'b0101;   // bit k = 1 means data is granted in cycle k
    reset = 1; step(); reset = 0;
    if0.inst_req = 1; if0.inst_addr = 32'h1000;
    if0.data_req = 1; if0.data_addr = 32'h2000; if0.data_wr = 0;
    for (int k = 0; k < 4; k++) begin
      if0.sram_rdata = 32'hA000_0000 + k;
      #1;
      vectors++;
      if (if0.data_addr_ok !== exp_d[k] || if0.inst_addr_ok !== !exp_d[k] ||
          if0.sram_addr !== (exp_d[k] ? 32'h2000 : 32'h1000)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got ok_d=%b ok_i=%b addr=%h required ok_d=%b",
                 k, if0.data_addr_ok, if0.inst_addr_ok, if0.sram_addr, exp_d[k]);
      end
      if (k > 0) begin
        vectors++;
        if (if0.data_data_ok !== exp_d[k-1] || if0.inst_data_ok !== !exp_d[k-1]) begin
          miscompares++;
          $display("FAIL rr_resp[%0d]: got dok=%b iok=%b required dok=%b",
                   k, if0.data_data_ok, if0.inst_data_ok, exp_d[k-1]);
        end
      end
      step();
    end
    idle_inputs();
    if0.sram_rdata = 32'h7777_0003;
    #1;
    vectors++;
    if (if0.inst_data_ok !== 1'b1 || if0.data_data_ok !== 1'b0 || if0.inst_rdata !== 32'h7777_0003) begin
      miscompares++;
      $display("FAIL rr_last_resp: got iok=%b dok=%b rdata=%h required 1 0 77770003",
               if0.inst_data_ok, if0.data_data_ok, if0.inst_rdata);
    end
    vectors++;
    if (if0.conflict_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL rr_conflict_cnt: got %0d required 4", if0.conflict_cnt);
    end
    step();
  endtask

  task automatic test_data_prio();
    reset = 1; step(); reset = 0;
    if1.inst_req = 1; if1.inst_addr = 32'h3000;
    if1.data_req = 1; if1.data_addr = 32'h4000;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (if1.data_addr_ok !== 1'b1 || if1.inst_addr_ok !== 1'b0 || if1.sram_addr !== 32'h4000) begin
        miscompares++;
        $display("FAIL prio_grant[%0d]: got ok_d=%b ok_i=%b addr=%h required 1 0 4000",
                 k, if1.data_addr_ok, if1.inst_addr_ok, if1.sram_addr);
      end
      step();
    end
    idle_inputs();
    #1;
    vectors++;
    if (if1.conflict_cnt !== 16'd3 || if1.data_data_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_cnt: got cnt=%0d dok=%b required 3 1", if1.conflict_cnt, if1.data_data_ok);
    end
    step();
  endtask

  // A fetch grant followed immediately by reset must never produce data_ok.
  task automatic test_reset_drop();
    if0.inst_req = 1; if0.data_req = 1; if0.inst_addr = 32'h10; if0.data_addr = 32'h20;
    step();   // conflict makes conflict_cnt nonzero before reset
    if0.data_req = 0;
    step();   // fetch granted here
    idle_inputs();
    reset = 1;
    if0.sram_rdata = 32'hFFFF_0000;
    #1;
    vectors++;
    if (if0.inst_data_ok !== 1'b0 || if0.inst_rdata !== 32'h0 || if0.data_data_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drop_resp: got iok=%b rdata=%h dok=%b required 0 0 0",
               if0.inst_data_ok, if0.inst_rdata, if0.data_data_ok);
    end
    step();
    reset = 0;
    #1;
    vectors++;
    if (if0.inst_data_ok !== 1'b0 || if0.data_data_ok !== 1'b0 || if0.conflict_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_drop_after: got iok=%b dok=%b cnt=%h required 0 0 0000",
               if0.inst_data_ok, if0.data_data_ok, if0.conflict_cnt);
    end
    step();
    if0.sram_rdata = 0;
  endtask

  task automatic test_saturation();
    reset = 1; step(); reset = 0;
    if0.inst_req = 1; if0.data_req = 1;
    for (int k = 0; k < 65534; k++) begin
      @(posedge clk);
    end
    #1;
    vectors++;
    if (if0.conflict_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_preload: got %h required fffe", if0.conflict_cnt);
    end
    step(); step(); step();
    vectors++;
    if (if0.conflict_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %h required ffff", if0.conflict_cnt);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_round_robin();
    test_data_prio();
    test_reset_drop();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
